led_matrix_capture: RTL and testbench
=====================================

Name: led_matrix_capture

Overview:
- Receive-side counterpart of the 8x8 column-scanned LED matrix driver.
- Samples the multiplexed rows/colms pins and reconstructs the displayed 64-bit array, one column per scan step.
- Publishes each complete frame with a one-cycle valid strobe.
- Used for loopback self-test of the matrix path and for mirroring a remote display.

Parameters:
- SETTLE, 4: consecutive identical synchronized samples required before a column is captured (1..15).
- TIMEOUT, 1024: consecutive cycles with no active column before the capture is abandoned (2..65535).

Ports:
- stateClk  input  1  sampling clock; must be at least 4x faster than the driver's column step.
- rst  input  1  reset, asynchronous, active-high.
- an  input  1  polarity, same meaning as at the driver (static).
- rows  input  8  row pins from the driver.
- colms  input  8  column pins from the driver.
- frame  output  64  last complete frame; bit 8*r+c = row r, column c; 1 = lit.
- frame_valid  output  1  one-cycle pulse when frame updates.
- busy  output  1  high while a frame is partially captured.
- err  output  1  one-cycle pulse on protocol violation.
- col_idx  output  3  next column expected.

Behaviour:
- Reset: all of the following clear immediately and asynchronously: frame=0, frame_valid=0, busy=0, err=0, col_idx=0, shadow buffer=0, synchronizers=0, counters=0, state=IDLE.
- Input path: rows and colms each pass through a 2-flop synchronizer.
- Decode, on synchronized values:
  - act = colms_s ^ {8{~an}}; a column is active when its pin equals an.
  - lit = rows_s ^ {8{an}}.
  - act is valid only when one-hot; its index is k.
- Stability counter:
  - Increments while {act,lit} equals the previous cycle's value; otherwise reloads to 1.
  - Saturates at SETTLE.
  - "stable" means counter == SETTLE.
- States:
  - IDLE: busy=0. On stable, one-hot act with k==0: capture, go to HOLD, col_idx=1, busy=1. All other act values are ignored, with no err.
  - HOLD: column k captured; waits for act to change.
    - act == 0: enter BLANK.
    - One-hot act with index == col_idx: go to SETTLE.
    - One-hot act with the same index as already captured: stay.
    - Any other one-hot index: err pulse, go to IDLE.
    - Multi-hot act: err pulse, go to IDLE.
  - SETTLE: waits for stable.
    - Stable with index == col_idx: capture and return to HOLD.
    - act changes to a different non-zero value before stable: err pulse, go to IDLE.
  - BLANK: act == 0 counts the timeout counter.
    - Counter reaches TIMEOUT: go to IDLE silently (busy=0, col_idx=0, shadow discarded).
    - Non-zero act: handle exactly as in HOLD.
- Capture of column k: shadow bit 8*r+k = lit[r] for r=0..7.
  - If k==7: frame <= shadow including the new column; frame_valid=1 on the next cycle; go to IDLE; col_idx=0. IDLE immediately accepts the next column 0 after it is stable, so continuous scanning produces one frame per scan.
  - Otherwise col_idx = k+1.
- frame holds its value between frame_valid pulses.
- An abandoned or errored capture never alters frame.
- Latency: from a pin change to capture = 2 (sync) + SETTLE cycles; frame_valid is asserted 1 cycle after the column-7 capture.
- Simultaneous events: err and frame_valid are never asserted in the same cycle.
- rst mid-capture: the partial shadow is lost; frame is cleared to 0.
- an toggling is unsupported (static strap); behaviour undefined.

Test Plan:
- Driver model, an=0, array=64'h0018242424241800, column step every 16 clocks → frame_valid once per 128-cycle scan; frame equals the array; err is never asserted.
- Same stimulus with an=1 (all pins inverted) → identical frame.
- Scan sequence 0,1,2,4 → err pulse when column 4 becomes stable-candidate; frame unchanged; next clean scan produces frame_valid.
- colms pattern with 2 active columns during column 3 → err pulse; state returns to IDLE; busy=0.
- Driver en=0 (all columns inactive) mid-frame for 1100 cycles, TIMEOUT=1024 → busy drops at cycle 1024 with no err; frame unchanged.
- Column 5 glitch shorter than SETTLE (2 cycles) during column 4 → err when the next change occurs; also, with a 1-cycle row glitch within the same column, no err and the captured data is the settled value.
- Assert rst during column 5 → frame=0, busy=0, col_idx=0 within the same cycle; a full scan after release produces a correct frame.

Source files
------------

// File: rtl/led_matrix_capture.sv
// led_matrix_capture
//   Receive side of an 8x8 column-scanned LED matrix link. Samples the
//   multiplexed row/column pins, waits for each column to settle, and rebuilds
//   the displayed 64-bit array one column at a time. A completed scan is
//   published on o_frame with a one-cycle o_frame_valid strobe.
//
// Ports
//   stateClk       sampling clock (at least 4x the driver column step rate)
//   rst            asynchronous active-high reset
//   i_an           pin polarity strap, same meaning as at the driver
//   i_rows[7:0]    row pins
//   i_colms[7:0]   column pins
//   o_frame[63:0]  last complete frame, bit 8*r+c = row r / column c, 1 = lit
//   o_frame_valid  one-cycle pulse when o_frame updates
//   o_busy         a frame is partially captured
//   o_err          one-cycle pulse on a scan protocol violation
//   o_col_idx[2:0] next column expected
module led_matrix_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        stateClk,
  input  logic        rst,
  input  logic        i_an,
  input  logic [7:0]  i_rows,
  input  logic [7:0]  i_colms,
  output logic [63:0] o_frame,
  output logic        o_frame_valid,
  output logic        o_busy,
  output logic        o_err,
  output logic [2:0]  o_col_idx
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SETTLE, S_BLANK} state_t;

  localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
  localparam logic [16:0] TIMEOUT_C = 17'(TIMEOUT);

  // Saturating increment of the stability counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= SETTLE_C) ? SETTLE_C : c + 4'd1;
  endfunction

  // Insert one column (lit[r] -> bit 8*r+k) into a 64-bit array.
  function automatic logic [63:0] ins_col(input logic [63:0] sh,
                                          input logic [2:0]  k,
                                          input logic [7:0]  lit);
    logic [63:0] s;
    logic [5:0]  idx;
    s = sh;
    for (int r = 0; r < 8; r++) begin
      idx    = {3'(r), k};
      s[idx] = lit[r];
    end
    return s;
  endfunction

  logic [7:0]  r_rows_p0, r_rows_p1;
  logic [7:0]  r_colms_p0, r_colms_p1;
  logic [15:0] r_prev_p2;
  logic [3:0]  r_stab_cnt;
  logic [15:0] r_to_cnt;
  state_t      r_state;
  logic [2:0]  r_col_idx;
  logic [2:0]  r_cap_idx;
  logic [63:0] r_shadow;
  logic [63:0] r_frame;
  logic        r_frame_valid;
  logic        r_err;

  logic [7:0]  w_act;
  logic [7:0]  w_lit;
  logic        w_onehot;
  logic [2:0]  w_k;
  logic [3:0]  w_stab_nxt;
  logic        w_stable;

  state_t      w_state_nxt;
  logic [2:0]  w_col_nxt;
  logic [2:0]  w_cap_nxt;
  logic [63:0] w_shadow_nxt;
  logic [63:0] w_frame_nxt;
  logic        w_fv_nxt;
  logic        w_err_nxt;
  logic [15:0] w_to_nxt;
  logic        w_capture;
  logic        w_abort;

  // ---- stage p0/p1: two-flop synchronizers on the pins ----
  always_ff @(posedge stateClk or posedge rst) begin
    if (rst) begin
      r_rows_p0  <= 8'd0;
      r_rows_p1  <= 8'd0;
      r_colms_p0 <= 8'd0;
      r_colms_p1 <= 8'd0;
    end else begin
      r_rows_p0  <= i_rows;
      r_rows_p1  <= r_rows_p0;
      r_colms_p0 <= i_colms;
      r_colms_p1 <= r_colms_p0;
    end
  end

  // ---- stage p2: polarity decode and stability tracking ----
  assign w_act    = r_colms_p1 ^ {8{~i_an}};
  assign w_lit    = r_rows_p1 ^ {8{i_an}};
  assign w_onehot = (w_act != 8'd0) && ((w_act & (w_act - 8'd1)) == 8'd0);

  always_comb begin
    w_k = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_act[i]) w_k = 3'(i);
    end
  end

  // The counter value for the current cycle includes this cycle, so a value
  // first seen now counts as 1 and is stable after SETTLE cycles in total.
  assign w_stab_nxt = ({w_act, w_lit} == r_prev_p2) ? sat_inc(r_stab_cnt) : 4'd1;
  assign w_stable   = (w_stab_nxt == SETTLE_C);

  always_ff @(posedge stateClk or posedge rst) begin
    if (rst) begin
      r_prev_p2  <= 16'd0;
      r_stab_cnt <= 4'd0;
    end else begin
      r_prev_p2  <= {w_act, w_lit};
      r_stab_cnt <= w_stab_nxt;
    end
  end

  // ---- scan-tracking FSM: next state ----
  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col_idx;
    w_cap_nxt    = r_cap_idx;
    w_shadow_nxt = r_shadow;
    w_frame_nxt  = r_frame;
    w_fv_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
    w_to_nxt     = 16'd0;
    w_capture    = 1'b0;
    w_abort      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_stable && w_onehot && (w_k == 3'd0)) w_capture = 1'b1;
      end

      S_HOLD, S_BLANK: begin
        if (w_act == 8'd0) begin
          if (r_state == S_HOLD) begin
            w_state_nxt = S_BLANK;
            w_to_nxt    = 16'd1;
          end else if (({1'b0, r_to_cnt} + 17'd1) >= TIMEOUT_C) begin
            w_abort = 1'b1;
          end else begin
            w_to_nxt = r_to_cnt + 16'd1;
          end
        end else if (!w_onehot) begin
          w_abort   = 1'b1;
          w_err_nxt = 1'b1;
        end else if (w_k == r_col_idx) begin
          w_state_nxt = S_SETTLE;
        end else if (w_k == r_cap_idx) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_abort   = 1'b1;
          w_err_nxt = 1'b1;
        end
      end

      S_SETTLE: begin
        if (w_stable && w_onehot && (w_k == r_col_idx)) begin
          w_capture = 1'b1;
        end else if (w_act == 8'd0) begin
          w_state_nxt = S_BLANK;
          w_to_nxt    = 16'd1;
        end else if (!(w_onehot && (w_k == r_col_idx))) begin
          w_abort   = 1'b1;
          w_err_nxt = 1'b1;
        end
      end

      default: begin
        w_abort = 1'b1;
      end
    endcase

    if (w_capture) begin
      if (w_k == 3'd7) begin
        // Last column completes the frame; IDLE is ready for the next column 0.
        w_frame_nxt  = ins_col(r_shadow, 3'd7, w_lit);
        w_fv_nxt     = 1'b1;
        w_state_nxt  = S_IDLE;
        w_col_nxt    = 3'd0;
        w_shadow_nxt = 64'd0;
      end else begin
        w_shadow_nxt = ins_col(r_shadow, w_k, w_lit);
        w_state_nxt  = S_HOLD;
        w_col_nxt    = w_k + 3'd1;
        w_cap_nxt    = w_k;
      end
    end

    // Abandoned or errored captures drop the shadow and never touch the frame.
    if (w_abort) begin
      w_state_nxt  = S_IDLE;
      w_col_nxt    = 3'd0;
      w_cap_nxt    = 3'd0;
      w_shadow_nxt = 64'd0;
    end
  end

  // ---- scan-tracking FSM: state and output registers ----
  always_ff @(posedge stateClk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_col_idx     <= 3'd0;
      r_cap_idx     <= 3'd0;
      r_shadow      <= 64'd0;
      r_frame       <= 64'd0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
      r_to_cnt      <= 16'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_col_idx     <= w_col_nxt;
      r_cap_idx     <= w_cap_nxt;
      r_shadow      <= w_shadow_nxt;
      r_frame       <= w_frame_nxt;
      r_frame_valid <= w_fv_nxt;
      r_err         <= w_err_nxt;
      r_to_cnt      <= w_to_nxt;
    end
  end

  assign o_frame       = r_frame;
  assign o_frame_valid = r_frame_valid;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err         = r_err;
  assign o_col_idx     = r_col_idx;

endmodule

// File: tb/tb_led_matrix_capture.sv
// tb_led_matrix_capture
//   Directed bench for led_matrix_capture. A small driver model presents an
//   8x8 array column by column on the pins; each scenario task checks the
//   reconstructed frame, strobes and status against hand-derived values.
module tb_led_matrix_capture;

  localparam logic [63:0] ARR_A = 64'h0018242424241800;
  localparam logic [63:0] ARR_C = 64'h0123456789ABCDEF;
  localparam logic [63:0] ARR_D = 64'hF00F55AAC33C0FF0;

  logic        stateClk = 1'b0;
  logic        rst;
  logic        an;
  logic [7:0]  rows;
  logic [7:0]  colms;
  logic [63:0] frame;
  logic        frame_valid;
  logic        busy;
  logic        err;
  logic [2:0]  col_idx;

  int n_pass  = 0;
  int n_total = 0;
  int fv_cnt  = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  led_matrix_capture #(.SETTLE(4), .TIMEOUT(1024)) dut (
    .stateClk      (stateClk),
    .rst           (rst),
    .i_an          (an),
    .i_rows        (rows),
    .i_colms       (colms),
    .o_frame       (frame),
    .o_frame_valid (frame_valid),
    .o_busy        (busy),
    .o_err         (err),
    .o_col_idx     (col_idx)
  );

  always #5 stateClk = ~stateClk;

  // Pulse monitors: count high cycles of the strobes.
  always @(negedge stateClk) begin
    if (frame_valid) fv_cnt = fv_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
    if (err && frame_valid) both_cnt = both_cnt + 1;
  end

  function automatic logic [7:0] colbits(input logic [63:0] arr, input int k);
    logic [7:0] b;
    logic [5:0] ix;
    for (int r = 0; r < 8; r++) begin
      ix   = {3'(r), 3'(k)};
      b[r] = arr[ix];
    end
    return b;
  endfunction

  // Drive logical active-column and lit-row vectors onto the pins.
  task automatic set_pins(input logic [7:0] act, input logic [7:0] lit);
    colms = act ^ {8{~an}};
    rows  = lit ^ {8{an}};
  endtask

  // Present column k of arr for a number of cycles; at cycle glitch_at the
  // row pins show the inverted data for that one cycle.
  task automatic step(input int k, input logic [63:0] arr, input int cycles, input int glitch_at);
    logic [7:0] oh;
    logic [7:0] lit;
    for (int c = 0; c < cycles; c++) begin
      @(posedge stateClk); #1;
      oh  = 8'd1 << k;
      lit = colbits(arr, k);
      if (c == glitch_at) lit = ~lit;
      set_pins(oh, lit);
    end
  endtask

  task automatic scan(input logic [63:0] arr);
    for (int k = 0; k < 8; k++) step(k, arr, 16, -1);
  endtask

  task automatic idle_cycles(input int n);
    @(posedge stateClk); #1;
    set_pins(8'h00, 8'h00);
    repeat (n) @(posedge stateClk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    an  = 1'b0;
    set_pins(8'h00, 8'h00);
    repeat (3) @(posedge stateClk);
    #1;
    n_total++; if (frame !== 64'd0) $display("FAIL reset_frame: got %h expected %h", frame, 64'd0); else n_pass++;
    n_total++; if (frame_valid !== 1'b0) $display("FAIL reset_fv: got %b expected 0", frame_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
    n_total++; if (col_idx !== 3'd0) $display("FAIL reset_col_idx: got %0d expected 0", col_idx); else n_pass++;
    rst = 1'b0;
    repeat (2) @(posedge stateClk);
  endtask

  task automatic test_scan_an0;
    int f0, e0;
    f0 = fv_cnt; e0 = err_cnt;
    for (int k = 0; k < 3; k++) step(k, ARR_A, 16, -1);
    n_total++; if (col_idx !== 3'd3) $display("FAIL an0_mid_col_idx: got %0d expected 3", col_idx); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL an0_mid_busy: got %b expected 1", busy); else n_pass++;
    for (int k = 3; k < 8; k++) step(k, ARR_A, 16, -1);
    scan(ARR_A);
    n_total++; if (fv_cnt - f0 !== 2) $display("FAIL an0_fv_count: got %0d expected 2", fv_cnt - f0); else n_pass++;
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL an0_err_count: got %0d expected 0", err_cnt - e0); else n_pass++;
    n_total++; if (frame !== ARR_A) $display("FAIL an0_frame: got %h expected %h", frame, ARR_A); else n_pass++;
  endtask

  task automatic test_scan_an1;
    int f0, e0;
    rst = 1'b1;
    an  = 1'b1;
    set_pins(8'h00, 8'h00);
    repeat (2) @(posedge stateClk);
    #1;
    rst = 1'b0;
    n_total++; if (frame !== 64'd0) $display("FAIL an1_frame_after_reset: got %h expected %h", frame, 64'd0); else n_pass++;
    f0 = fv_cnt; e0 = err_cnt;
    scan(ARR_A);
    n_total++; if (fv_cnt - f0 !== 1) $display("FAIL an1_fv_count: got %0d expected 1", fv_cnt - f0); else n_pass++;
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL an1_err_count: got %0d expected 0", err_cnt - e0); else n_pass++;
    n_total++; if (frame !== ARR_A) $display("FAIL an1_frame: got %h expected %h", frame, ARR_A); else n_pass++;
    rst = 1'b1;
    an  = 1'b0;
    set_pins(8'h00, 8'h00);
    repeat (2) @(posedge stateClk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_skip;
    int f0, e0;
    scan(ARR_A);
    e0 = err_cnt;
    step(0, ARR_C, 16, -1);
    step(1, ARR_C, 16, -1);
    step(2, ARR_C, 16, -1);
    step(4, ARR_C, 16, -1);
    n_total++; if (err_cnt - e0 !== 1) $display("FAIL skip_err_count: got %0d expected 1", err_cnt - e0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL skip_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (col_idx !== 3'd0) $display("FAIL skip_col_idx: got %0d expected 0", col_idx); else n_pass++;
    n_total++; if (frame !== ARR_A) $display("FAIL skip_frame_kept: got %h expected %h", frame, ARR_A); else n_pass++;
    f0 = fv_cnt;
    scan(ARR_C);
    n_total++; if (fv_cnt - f0 !== 1) $display("FAIL skip_recover_fv: got %0d expected 1", fv_cnt - f0); else n_pass++;
    n_total++; if (frame !== ARR_C) $display("FAIL skip_recover_frame: got %h expected %h", frame, ARR_C); else n_pass++;
  endtask

  task automatic test_multihot;
    int e0;
    e0 = err_cnt;
    for (int k = 0; k < 4; k++) step(k, ARR_A, 16, -1);
    @(posedge stateClk); #1;
    set_pins(8'b0010_1000, colbits(ARR_A, 3));
    repeat (8) @(posedge stateClk);
    #1;
    n_total++; if (err_cnt - e0 !== 1) $display("FAIL multihot_err_count: got %0d expected 1", err_cnt - e0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL multihot_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (col_idx !== 3'd0) $display("FAIL multihot_col_idx: got %0d expected 0", col_idx); else n_pass++;
    n_total++; if (frame !== ARR_C) $display("FAIL multihot_frame_kept: got %h expected %h", frame, ARR_C); else n_pass++;
    idle_cycles(8);
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_cnt;
    for (int k = 0; k < 4; k++) step(k, ARR_A, 16, -1);
    idle_cycles(1000);
    n_total++; if (busy !== 1'b1) $display("FAIL timeout_busy_before: got %b expected 1", busy); else n_pass++;
    n_total++; if (col_idx !== 3'd4) $display("FAIL timeout_col_idx_before: got %0d expected 4", col_idx); else n_pass++;
    repeat (100) @(posedge stateClk);
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL timeout_busy_after: got %b expected 0", busy); else n_pass++;
    n_total++; if (col_idx !== 3'd0) $display("FAIL timeout_col_idx_after: got %0d expected 0", col_idx); else n_pass++;
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL timeout_err_count: got %0d expected 0", err_cnt - e0); else n_pass++;
    n_total++; if (frame !== ARR_C) $display("FAIL timeout_frame_kept: got %h expected %h", frame, ARR_C); else n_pass++;
  endtask

  task automatic test_glitch;
    int f0, e0;
    e0 = err_cnt;
    for (int k = 0; k < 5; k++) step(k, ARR_A, 16, -1);
    step(5, ARR_A, 2, -1);
    step(4, ARR_A, 10, -1);
    n_total++; if (err_cnt - e0 !== 1) $display("FAIL col_glitch_err_count: got %0d expected 1", err_cnt - e0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL col_glitch_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (frame !== ARR_C) $display("FAIL col_glitch_frame_kept: got %h expected %h", frame, ARR_C); else n_pass++;
    f0 = fv_cnt; e0 = err_cnt;
    for (int k = 0; k < 8; k++) step(k, ARR_D, 16, (k == 2) ? 0 : ((k == 6) ? 10 : -1));
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL row_glitch_err_count: got %0d expected 0", err_cnt - e0); else n_pass++;
    n_total++; if (fv_cnt - f0 !== 1) $display("FAIL row_glitch_fv: got %0d expected 1", fv_cnt - f0); else n_pass++;
    n_total++; if (frame !== ARR_D) $display("FAIL row_glitch_frame: got %h expected %h", frame, ARR_D); else n_pass++;
  endtask

  task automatic test_rst_mid;
    int f0, e0;
    for (int k = 0; k < 5; k++) step(k, ARR_A, 16, -1);
    step(5, ARR_A, 8, -1);
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (frame !== 64'd0) $display("FAIL rstmid_frame: got %h expected %h", frame, 64'd0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (col_idx !== 3'd0) $display("FAIL rstmid_col_idx: got %0d expected 0", col_idx); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rstmid_err: got %b expected 0", err); else n_pass++;
    n_total++; if (frame_valid !== 1'b0) $display("FAIL rstmid_fv: got %b expected 0", frame_valid); else n_pass++;
    repeat (3) @(posedge stateClk);
    #1;
    rst = 1'b0;
    f0 = fv_cnt; e0 = err_cnt;
    scan(ARR_A);
    n_total++; if (fv_cnt - f0 !== 1) $display("FAIL rstmid_recover_fv: got %0d expected 1", fv_cnt - f0); else n_pass++;
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL rstmid_recover_err: got %0d expected 0", err_cnt - e0); else n_pass++;
    n_total++; if (frame !== ARR_A) $display("FAIL rstmid_recover_frame: got %h expected %h", frame, ARR_A); else n_pass++;
  endtask

  initial begin
    rst   = 1'b1;
    an    = 1'b0;
    rows  = 8'h00;
    colms = 8'hFF;
    test_reset();
    test_scan_an0();
    test_scan_an1();
    test_skip();
    test_multihot();
    test_timeout();
    test_glitch();
    test_rst_mid();
    n_total++; if (both_cnt !== 0) $display("FAIL err_with_fv: got %0d expected 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
